// File: rtl/fir_host_driver_pkg.sv
// Shared types and register map for the FIR host driver.
package fir_host_driver_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StWrTap,
      StWrLen,
      StWrStart,
      StStream,
      StPoll,
      StDone
   } state_t;

   localparam int unsigned ADDR_CTRL   = 32'h00;
   localparam int unsigned ADDR_LEN    = 32'h10;
   localparam int unsigned ADDR_TAP    = 32'h40;
   localparam int unsigned AP_DONE_BIT = 1;

endpackage

// File: rtl/fir_host_driver_axil_wr.sv
// Single AXI-Lite write: go launches aw+w together, each valid drops on its
// own ready, and wdone pulses once after both channels have handshaken.
module axil_wr_master #(
   parameter int unsigned pADDR_WIDTH = 12,
   parameter int unsigned pDATA_WIDTH = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   go,
   input  logic [pADDR_WIDTH-1:0] addr,
   input  logic [pDATA_WIDTH-1:0] data,
   output logic                   awvalid,
   input  logic                   awready,
   output logic [pADDR_WIDTH-1:0] awaddr,
   output logic                   wvalid,
   input  logic                   wready,
   output logic [pDATA_WIDTH-1:0] wdata,
   output logic                   wdone
);

   logic aw_ok;
   logic w_ok;

   // A channel counts as finished if it is already idle or handshakes now
   assign aw_ok = !awvalid || awready;
   assign w_ok  = !wvalid || wready;

   // Launch, per-channel retirement and completion pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         awvalid <= 1'b0;
         wvalid  <= 1'b0;
         awaddr  <= '0;
         wdata   <= '0;
         wdone   <= 1'b0;
      end else begin
         wdone <= 1'b0;
         if (go) begin
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            awaddr  <= addr;
            wdata   <= data;
         end else begin
            if (awvalid && awready) awvalid <= 1'b0;
            if (wvalid && wready)   wvalid  <= 1'b0;
            if ((awvalid || wvalid) && aw_ok && w_ok) wdone <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/fir_host_driver.sv
// Host-side driver for an AXI-Lite/AXIS FIR core: programs taps and length,
// starts the core, streams samples while collecting results.
// Optional feature macro: FIR_HOST_POLL_EN (poll ap_done after streaming).
module fir_host_driver
   import fir_host_driver_pkg::*;
#(
   parameter int unsigned pADDR_WIDTH = 12,
   parameter int unsigned pDATA_WIDTH = 32,
   parameter int unsigned Tape_Num    = 11
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst_n,
   input  logic                   start,
   input  logic [31:0]            cfg_length,
   output logic                   busy,
   output logic                   done,
   output logic                   err,
   output logic [31:0]            idx,
   input  logic [pDATA_WIDTH-1:0] tap_val,
   input  logic [pDATA_WIDTH-1:0] smp_val,
   output logic                   res_valid,
   output logic                   res_last,
   output logic [pDATA_WIDTH-1:0] res_data,
   output logic                   awvalid,
   input  logic                   awready,
   output logic [pADDR_WIDTH-1:0] awaddr,
   output logic                   wvalid,
   input  logic                   wready,
   output logic [pDATA_WIDTH-1:0] wdata,
   output logic                   arvalid,
   input  logic                   arready,
   output logic [pADDR_WIDTH-1:0] araddr,
   input  logic                   rvalid,
   output logic                   rready,
   input  logic [pDATA_WIDTH-1:0] rdata,
   output logic                   ss_tvalid,
   output logic                   ss_tlast,
   output logic [pDATA_WIDTH-1:0] ss_tdata,
   input  logic                   ss_tready,
   input  logic                   sm_tvalid,
   input  logic                   sm_tlast,
   input  logic [pDATA_WIDTH-1:0] sm_tdata,
   output logic                   sm_tready
);

   state_t                   state_q;
   logic [31:0]              len_q;
   logic [31:0]              n_q;
   logic [31:0]              m_q;
   logic                     wr_pend_q;
   logic                     wr_go;
   logic                     wr_done;
   logic [pADDR_WIDTH-1:0]   wr_addr;
   logic [pDATA_WIDTH-1:0]   wr_data;
   logic                     ss_hs;
   logic                     sm_hs;
   logic [31:0]              n_nxt;
   logic [31:0]              m_nxt;

   assign ss_hs    = ss_tvalid && ss_tready;
   assign sm_hs    = sm_tvalid && sm_tready;
   assign n_nxt    = n_q + {31'b0, ss_hs};
   assign m_nxt    = m_q + {31'b0, sm_hs};
   assign ss_tdata = ss_tvalid ? smp_val : '0;
   assign araddr   = pADDR_WIDTH'(ADDR_CTRL);

`ifndef FIR_HOST_POLL_EN
   logic unused_rd;
   assign arvalid   = 1'b0;
   assign rready    = 1'b0;
   assign unused_rd = ^{arready, rvalid, rdata};
`endif

   // Select the write to issue for the current programming state
   always_comb begin
      wr_go   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
      unique case (state_q)
         StWrTap: begin
            wr_go   = !wr_pend_q;
            wr_addr = pADDR_WIDTH'(ADDR_TAP + (idx << 2));
            wr_data = tap_val;
         end
         StWrLen: begin
            wr_go   = !wr_pend_q;
            wr_addr = pADDR_WIDTH'(ADDR_LEN);
            wr_data = pDATA_WIDTH'(len_q);
         end
         StWrStart: begin
            wr_go   = !wr_pend_q;
            wr_addr = pADDR_WIDTH'(ADDR_CTRL);
            wr_data = pDATA_WIDTH'(1);
         end
         default: ;
      endcase
   end

   axil_wr_master #(
      .pADDR_WIDTH(pADDR_WIDTH),
      .pDATA_WIDTH(pDATA_WIDTH)
   ) u_wr (
      .clk    (axis_clk),
      .rst_n  (axis_rst_n),
      .go     (wr_go),
      .addr   (wr_addr),
      .data   (wr_data),
      .awvalid(awvalid),
      .awready(awready),
      .awaddr (awaddr),
      .wvalid (wvalid),
      .wready (wready),
      .wdata  (wdata),
      .wdone  (wr_done)
   );

   // Main sequencer with registered status and stream outputs
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state_q   <= StIdle;
         len_q     <= '0;
         n_q       <= '0;
         m_q       <= '0;
         wr_pend_q <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
         idx       <= '0;
         res_valid <= 1'b0;
         res_last  <= 1'b0;
         res_data  <= '0;
         ss_tvalid <= 1'b0;
         ss_tlast  <= 1'b0;
         sm_tready <= 1'b0;
`ifdef FIR_HOST_POLL_EN
         arvalid   <= 1'b0;
         rready    <= 1'b0;
`endif
      end else begin
         done      <= 1'b0;
         res_valid <= 1'b0;
         res_last  <= 1'b0;
         if (wr_go) wr_pend_q <= 1'b1;
         unique case (state_q)
            StIdle: begin
               if (start) begin
                  len_q   <= cfg_length;
                  err     <= 1'b0;
                  n_q     <= '0;
                  m_q     <= '0;
                  idx     <= '0;
                  busy    <= 1'b1;
                  state_q <= StWrTap;
               end
            end
            StWrTap: begin
               if (wr_done) begin
                  wr_pend_q <= 1'b0;
                  if (idx == 32'(Tape_Num - 1)) begin
                     idx     <= '0;
                     state_q <= StWrLen;
                  end else begin
                     idx <= idx + 32'd1;
                  end
               end
            end
            StWrLen: begin
               if (wr_done) begin
                  wr_pend_q <= 1'b0;
                  if (len_q == '0) begin
                     done    <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     state_q <= StWrStart;
                  end
               end
            end
            StWrStart: begin
               if (wr_done) begin
                  wr_pend_q <= 1'b0;
                  idx       <= '0;
                  ss_tvalid <= 1'b1;
                  ss_tlast  <= (len_q == 32'd1);
                  sm_tready <= 1'b1;
                  state_q   <= StStream;
               end
            end
            StStream: begin
               n_q <= n_nxt;
               m_q <= m_nxt;
               if (ss_hs) begin
                  if (n_nxt == len_q) begin
                     ss_tvalid <= 1'b0;
                     ss_tlast  <= 1'b0;
                  end else begin
                     idx      <= n_nxt;
                     ss_tlast <= (n_nxt == len_q - 32'd1);
                  end
               end
               if (sm_hs) begin
                  res_valid <= 1'b1;
                  res_data  <= sm_tdata;
                  res_last  <= sm_tlast;
                  if (sm_tlast != (m_q == len_q - 32'd1)) err <= 1'b1;
               end
               if (n_nxt == len_q && m_nxt >= len_q) begin
                  sm_tready <= 1'b0;
`ifdef FIR_HOST_POLL_EN
                  arvalid   <= 1'b1;
                  state_q   <= StPoll;
`else
                  done      <= 1'b1;
                  state_q   <= StDone;
`endif
               end
            end
            StPoll: begin
`ifdef FIR_HOST_POLL_EN
               if (arvalid && arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
               end
               if (rready && rvalid) begin
                  rready <= 1'b0;
                  if (rdata[AP_DONE_BIT]) begin
                     done    <= 1'b1;
                     state_q <= StDone;
                  end else begin
                     arvalid <= 1'b1;
                  end
               end
`else
               state_q <= StIdle;
`endif
            end
            StDone: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule
